// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch redirect controller.
//   fetch_state_e     : fetch FSM states (RUN, FLUSH, HALT)
//   PC_INC            : byte increment of the fetch PC per sequential fetch
//   FLUSH_CYC_DEFAULT : default count of bubble cycles after a redirect
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    localparam int PC_INC            = 4;
    localparam int FLUSH_CYC_DEFAULT = 2;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset (count -> 0)
//   clear : synchronous clear (count -> 0)
//   inc   : increment by one; holds at all-ones
//   count : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl
// Owns the fetch PC: sequential +4 fetch, hazard stall, branch/jump redirect
// with IF/ID bubble injection, halt parking and misaligned-target trapping.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   PcSel, BrPC  : taken-redirect request and its byte target
//   stall        : hold the PC this cycle
//   flag_halt    : halt instruction reached EX
//   Cur_PC       : current fetch address
//   if_flush     : squash IF/ID this cycle
//   id_flush     : squash ID/EX this cycle
//   halted       : core parked in HALT
//   misalign_err : sticky, a redirect target was not word-aligned
//   redirect_cnt : saturating taken-redirect count (BRANCH_STATS_EN only)
// Optional feature macro: BRANCH_STATS_EN (adds redirect_cnt and an internal
// flush_cyc_cnt debug counter).
// ---------------------------------------------------------------------------
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int FLUSH_CYC = FLUSH_CYC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            stall,
    input  logic            flag_halt,
    output logic [PC_W-1:0] Cur_PC,
    output logic            if_flush,
    output logic            id_flush,
    output logic            halted,
    output logic            misalign_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     redirect_cnt
`endif
);

    localparam int             CNT_W    = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYC - 1);

    fetch_state_e     state_d, state_q;
    logic [PC_W-1:0]  cur_pc_d, cur_pc_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             misalign_d, misalign_q;
    logic             if_flush_c, id_flush_c;
    logic             redirect_ok;

    // Target bits above the PC width are dropped by design.
    logic unused_brpc_hi;
    assign unused_brpc_hi = ^BrPC[31:PC_W];

    // NOTE: every always_comb output gets a default first so no path leaves
    // a value unassigned; that is what keeps latches from being inferred.
    always_comb begin
        state_d     = state_q;
        cur_pc_d    = cur_pc_q;
        cnt_d       = cnt_q;
        misalign_d  = misalign_q;
        if_flush_c  = 1'b0;
        id_flush_c  = 1'b0;
        redirect_ok = 1'b0;

        unique case (state_q)
            RUN, FLUSH: begin
                if (flag_halt) begin
                    state_d    = HALT;
                    if_flush_c = 1'b1;
                    id_flush_c = 1'b1;
                end else if (PcSel) begin
                    if (BrPC[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        cur_pc_d    = BrPC[PC_W-1:0];
                        if_flush_c  = 1'b1;
                        id_flush_c  = 1'b1;
                        redirect_ok = 1'b1;
                        cnt_d       = CNT_LOAD;
                        state_d     = (CNT_LOAD != '0) ? FLUSH : RUN;
                    end
                end else begin
                    if (state_q == FLUSH) begin
                        if_flush_c = 1'b1;
                        cnt_d      = cnt_q - CNT_W'(1);
                        if (cnt_d == '0) begin
                            state_d = RUN;
                        end
                    end
                    if (!stall) begin
                        cur_pc_d = cur_pc_q + PC_W'(PC_INC);
                    end
                end
            end
            HALT: begin
                // Absorbing until reset.
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            cur_pc_q   <= '0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_pc_q   <= cur_pc_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    // Flushes are combinational; masking with reset keeps a reset issued
    // mid-FLUSH from squashing anything.
    assign if_flush     = if_flush_c & ~reset;
    assign id_flush     = id_flush_c & ~reset;
    assign Cur_PC       = cur_pc_q;
    assign halted       = (state_q == HALT);
    assign misalign_err = misalign_q;

`ifdef BRANCH_STATS_EN
    // Debug-visible count of cycles with an IF/ID squash.
    logic [15:0] flush_cyc_cnt;

    sat_counter #(.WIDTH(16)) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (redirect_ok),
        .count (redirect_cnt)
    );

    sat_counter #(.WIDTH(16)) u_flush_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (if_flush),
        .count (flush_cyc_cnt)
    );
`else
    logic unused_redirect_ok;
    assign unused_redirect_ok = redirect_ok;
`endif

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Owns the architectural fetch PC and consumes the branch unit's redirect outputs (PcSel, BrPC). It advances the PC by 4 each cycle, honours hazard stalls, and redirects on a taken branch/jump. It also drives IF/ID flush bubbles, parks the core on halt, and traps misaligned targets. Sits between the EX-stage branch unit and instruction memory.

Parameters:
PC_W, 9, fetch PC width in bits (instruction memory byte address)
FLUSH_CYC, 2, bubble cycles injected after a redirect (IF and ID squashed)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
PcSel  in  1  redirect request from branch unit; 1 = taken
BrPC  in  32  redirect target byte address
stall  in  1  hazard stall; hold PC
flag_halt  in  1  halt instruction reached EX
Cur_PC  out  PC_W  current fetch address
if_flush  out  1  squash IF/ID register this cycle
id_flush  out  1  squash ID/EX register this cycle
halted  out  1  core parked
misalign_err  out  1  sticky: redirect target not word-aligned
redirect_cnt  out  16  taken-redirect count (present only with macro; see Optional Feature)

Behaviour:
- Single clock, clk. reset is synchronous, active-high, sampled on the rising edge.
- Reset values: Cur_PC=0, if_flush=0, id_flush=0, halted=0, misalign_err=0, state=RUN.
- FSM states: RUN, FLUSH, HALT. Priority within one cycle: reset > flag_halt > PcSel > stall > increment.
- RUN, flag_halt=1 -> HALT next cycle. Cur_PC frozen. if_flush=id_flush=1 for that cycle.
- RUN, PcSel=1, BrPC[1:0]==0 -> Cur_PC <= BrPC[PC_W-1:0] next edge. Upper BrPC bits are silently truncated. if_flush=id_flush=1 combinationally in the same cycle. Go to FLUSH with cnt=FLUSH_CYC-1.
- RUN, PcSel=1, BrPC[1:0]!=0 -> misalign_err<=1 (sticky until reset), go to HALT, Cur_PC frozen.
- RUN, stall=1 and PcSel=0 -> Cur_PC held, no flush.
- PcSel and stall together -> redirect wins; stall ignored that cycle.
- RUN, otherwise -> Cur_PC <= Cur_PC+4, modulo 2^PC_W. Wrap from 2^PC_W-4 to 0 is legal and silent.
- FLUSH: if_flush=1, id_flush=0. Cur_PC increments unless stall=1. cnt decrements each cycle; at 0, return to RUN.
- In FLUSH, a new PcSel=1 is legal: re-redirect, cnt reloaded to FLUSH_CYC-1. flag_halt in FLUSH -> HALT.
- HALT: absorbing. halted=1 from the first cycle in HALT. Cur_PC held, flushes 0. All inputs ignored until reset.
- Reset mid-FLUSH or in HALT -> reset values on the next edge. No residual flush.
- Latency: redirect target appears on Cur_PC exactly 1 cycle after PcSel is sampled high.

Optional Feature:
BRANCH_STATS_EN. When defined: 16-bit redirect_cnt port and counter. It increments on every accepted aligned redirect, saturates at 0xFFFF, and resets to 0. A 16-bit flush_cyc_cnt counts cycles with if_flush=1 (saturating, internal, debug-visible). When undefined: port and counters absent, all other behaviour identical.

Decomposition:
- Shared package fetch_pkg: enum fetch_state_e {RUN, FLUSH, HALT}; localparam PC_INC=4; FLUSH_CYC default.
- One natural sub-module: sat_counter (parametric width, inc, clear, saturate), used twice under BRANCH_STATS_EN. FSM and PC register stay in fetch_redirect_ctrl.

Test Plan:
- Reset, then 5 free-run cycles -> Cur_PC 0,4,8,12,16. Flushes 0. halted 0.
- At Cur_PC=0x20: PcSel=1, BrPC=0x80 -> if_flush=id_flush=1 that cycle. Cur_PC=0x80 next. One further if_flush-only cycle. Then 0x84, 0x88.
- PcSel=1 and stall=1 together, BrPC=0x40 -> Cur_PC=0x40 next cycle (redirect wins). stall alone afterwards holds 0x40.
- PcSel=1, BrPC=0x00000102 -> misalign_err=1, halted=1 next cycle. Cur_PC frozen; later PcSel ignored. reset clears both.
- PC_W=9, Cur_PC=0x1FC, no events -> Cur_PC=0x000. BrPC=0xFFFF_FE10 -> Cur_PC=0x010 (truncated).
- flag_halt and PcSel in the same cycle -> halted=1, Cur_PC unchanged. With BRANCH_STATS_EN, redirect_cnt unchanged. Reset asserted in FLUSH -> all outputs reset next edge.
